ahb_slave_arbiter: RTL and testbench

Per-slave arbiter of the AHB interconnect, directly downstream of the per-master address decoders. It collects the one-hot `hreq` bit each master's decoder raises for this slave, grants exactly one master using round-robin priority, and holds the grant across bursts and locked sequences. It produces the address-phase and data-phase master indices that steer the slave-side multiplexers. Grant changes only at transfer boundaries while the slave is ready.

---
 rtl/AHB_package.sv | 45 ++++
 rtl/ahb_rr_picker.sv | 36 +++
 rtl/ahb_slave_arbiter.sv | 94 +++++++++
 tb/tb_ahb_slave_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/AHB_package.sv
// Shared AHB interconnect types plus the rotate-priority helper used by
// every arbiter in the fabric.
package AHB_package;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_LOCKED
    } arb_state_type;

    localparam int ARB_MAX_MASTERS = 16;
    localparam int ARB_MAX_IDX_W   = 4;

    typedef struct packed {
        logic                     any;
        logic [ARB_MAX_IDX_W-1:0] idx;
    } rr_result_type;

    // Callers zero-pad req above their master count. The padded positions then
    // sit between the last real master and index 0 in search order, so the
    // wrap-around still follows the caller's own modulo-N order.
    function automatic rr_result_type rr_next(input logic [ARB_MAX_MASTERS-1:0] req,
                                              input logic [ARB_MAX_IDX_W-1:0]   last);
        rr_result_type            res;
        logic [ARB_MAX_IDX_W-1:0] cand;
        res = '0;
        // Scan from the farthest position to the nearest, so the nearest hit wins.
        for (int k = ARB_MAX_MASTERS; k >= 1; k--) begin
            cand = last + ARB_MAX_IDX_W'(k);
            if (req[cand]) begin
                res.any = 1'b1;
                res.idx = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin search: picks the first request after 'last',
// wrapping modulo N. Returns both the one-hot form and the index form.
module ahb_rr_picker
    import AHB_package::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     win,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    logic [ARB_MAX_MASTERS-1:0] req_pad;
    logic [ARB_MAX_IDX_W-1:0]   last_pad;
    rr_result_type              res;

    // NOTE: every signal written in always_comb is given a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        req_pad            = '0;
        req_pad[N-1:0]     = req;
        last_pad           = '0;
        last_pad[IDX_W-1:0] = last;
        res                = rr_next(req_pad, last_pad);
        any                = res.any;
        win_idx            = res.idx[IDX_W-1:0];
        win                = '0;
        if (res.any) begin
            win[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: round-robin grant among requesting masters, held
// across SEQ/BUSY beats and locked sequences, advancing only when hready=1.
module ahb_slave_arbiter
    import AHB_package::*;
#(
    parameter int SLAVE_X_MASTER_NUM = 3,
    parameter int MASTER_IDX_W       = (SLAVE_X_MASTER_NUM > 1) ? $clog2(SLAVE_X_MASTER_NUM) : 1
) (
    input  logic                          hclk,
    input  logic                          hreset_n,
    input  logic [SLAVE_X_MASTER_NUM-1:0] hreq,
    input  htrans_type                    htrans [SLAVE_X_MASTER_NUM],
    input  logic [SLAVE_X_MASTER_NUM-1:0] hmastlock,
    input  logic                          hready,
    output logic [SLAVE_X_MASTER_NUM-1:0] hgrant,
    output logic                          hsel_slv,
    output logic [MASTER_IDX_W-1:0]       hmaster_addr,
    output logic [MASTER_IDX_W-1:0]       hmaster_data,
    output logic                          hmaster_lock
);

    localparam int N = SLAVE_X_MASTER_NUM;
    localparam int W = MASTER_IDX_W;

    arb_state_type state_q;
    logic [W-1:0]  owner_q;
    logic [W-1:0]  last_q;
    logic [W-1:0]  hmaster_data_q;
    logic [N-1:0]  grant_q;
    logic          lock_q;

    logic [N-1:0]  win;
    logic [W-1:0]  win_idx;
    logic          win_any;
    logic          hold;

    ahb_rr_picker #(
        .N    (N),
        .IDX_W(W)
    ) u_picker (
        .req    (hreq),
        .last   (last_q),
        .win    (win),
        .win_idx(win_idx),
        .any    (win_any)
    );

    // The owner keeps the bus while it is mid-burst or locked, but losing its
    // request (decoder moved to another slave) always releases it.
    always_comb begin
        hold = 1'b0;
        if (state_q != ARB_IDLE) begin
            hold = hreq[owner_q] & ((htrans[owner_q] == SEQ) | (htrans[owner_q] == BUSY)
                                    | hmastlock[owner_q]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q        <= ARB_IDLE;
            owner_q        <= '0;
            last_q         <= W'(N - 1);
            grant_q        <= '0;
            lock_q         <= 1'b0;
            hmaster_data_q <= '0;
        end else if (hready) begin
            hmaster_data_q <= owner_q;
            if (hold) begin
                state_q <= hmastlock[owner_q] ? ARB_LOCKED : ARB_GRANT;
                lock_q  <= hmastlock[owner_q];
            end else if (win_any) begin
                state_q <= hmastlock[win_idx] ? ARB_LOCKED : ARB_GRANT;
                owner_q <= win_idx;
                last_q  <= win_idx;
                grant_q <= win;
                lock_q  <= hmastlock[win_idx];
            end else begin
                state_q <= ARB_IDLE;
                owner_q <= '0;
                grant_q <= '0;
                lock_q  <= 1'b0;
            end
        end
    end

    assign hgrant       = grant_q;
    assign hmaster_addr = owner_q;
    assign hmaster_data = hmaster_data_q;
    assign hmaster_lock = lock_q;
    assign hsel_slv     = (|(grant_q & hreq)) & (htrans[owner_q] != IDLE);

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed bench for ahb_slave_arbiter with three masters: grant latency,
// burst hold, lock hold, hready stall, owner drop-out and async reset.
module tb_ahb_slave_arbiter;
    import AHB_package::*;

    logic       hclk = 1'b0;
    logic       hreset_n;
    logic [2:0] hreq;
    htrans_type htrans [3];
    logic [2:0] hmastlock;
    logic       hready;
    logic [2:0] hgrant;
    logic       hsel_slv;
    logic [1:0] hmaster_addr;
    logic [1:0] hmaster_data;
    logic       hmaster_lock;

    int checks = 0;
    int errors = 0;

    ahb_slave_arbiter #(.SLAVE_X_MASTER_NUM(3)) dut (
        .hclk        (hclk),
        .hreset_n    (hreset_n),
        .hreq        (hreq),
        .htrans      (htrans),
        .hmastlock   (hmastlock),
        .hready      (hready),
        .hgrant      (hgrant),
        .hsel_slv    (hsel_slv),
        .hmaster_addr(hmaster_addr),
        .hmaster_data(hmaster_data),
        .hmaster_lock(hmaster_lock)
    );

    always #5 hclk = ~hclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic set_htrans(input htrans_type t0, input htrans_type t1, input htrans_type t2);
        htrans[0] = t0;
        htrans[1] = t1;
        htrans[2] = t2;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        hreq      = 3'b000;
        hmastlock = 3'b000;
        hready    = 1'b1;
        set_htrans(IDLE, IDLE, IDLE);
        @(negedge hclk);
        hreset_n = 1'b0;
        @(negedge hclk);
        hreset_n = 1'b1;
    endtask

    task automatic test_reset();
        hreq      = 3'b000;
        hmastlock = 3'b000;
        hready    = 1'b1;
        set_htrans(IDLE, IDLE, IDLE);
        hreset_n = 1'b0;
        #12;
        checks++; if (hgrant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected %b", hgrant, 3'b000); end
        checks++; if (hsel_slv !== 1'b0) begin errors++; $display("FAIL reset_hsel: got %b expected 0", hsel_slv); end
        checks++; if (hmaster_addr !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", hmaster_addr); end
        checks++; if (hmaster_data !== 2'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", hmaster_data); end
        checks++; if (hmaster_lock !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b expected 0", hmaster_lock); end
        @(negedge hclk);
        hreset_n = 1'b1;
        step();
        checks++; if (hgrant !== 3'b000) begin errors++; $display("FAIL idle_no_req_grant: got %b expected %b", hgrant, 3'b000); end
    endtask

    task automatic test_grant_latency();
        do_reset();
        hreq = 3'b110;
        set_htrans(NONSEQ, NONSEQ, NONSEQ);
        step();
        checks++; if (hgrant !== 3'b010) begin errors++; $display("FAIL lat_grant: got %b expected %b", hgrant, 3'b010); end
        checks++; if (hmaster_addr !== 2'd1) begin errors++; $display("FAIL lat_addr: got %0d expected 1", hmaster_addr); end
        checks++; if (hmaster_data !== 2'd0) begin errors++; $display("FAIL lat_data0: got %0d expected 0", hmaster_data); end
        checks++; if (hsel_slv !== 1'b1) begin errors++; $display("FAIL lat_hsel: got %b expected 1", hsel_slv); end
        set_htrans(NONSEQ, SEQ, NONSEQ);
        step();
        checks++; if (hmaster_data !== 2'd1) begin errors++; $display("FAIL lat_data1: got %0d expected 1", hmaster_data); end
        checks++; if (hgrant !== 3'b010) begin errors++; $display("FAIL lat_hold_grant: got %b expected %b", hgrant, 3'b010); end
    endtask

    task automatic test_burst_hold();
        do_reset();
        hreq = 3'b010;
        set_htrans(NONSEQ, NONSEQ, NONSEQ);
        step();
        checks++; if (hgrant !== 3'b010) begin errors++; $display("FAIL burst_beat1: got %b expected %b", hgrant, 3'b010); end
        hreq = 3'b111;
        set_htrans(NONSEQ, SEQ, NONSEQ);
        for (int b = 2; b <= 4; b++) begin
            step();
            checks++; if (hgrant !== 3'b010) begin errors++; $display("FAIL burst_beat%0d: got %b expected %b", b, hgrant, 3'b010); end
        end
        set_htrans(NONSEQ, IDLE, NONSEQ);
        #1;
        checks++; if (hsel_slv !== 1'b0) begin errors++; $display("FAIL burst_hsel_idle: got %b expected 0", hsel_slv); end
        step();
        checks++; if (hgrant !== 3'b100) begin errors++; $display("FAIL burst_next_m2: got %b expected %b", hgrant, 3'b100); end
        step();
        checks++; if (hgrant !== 3'b001) begin errors++; $display("FAIL burst_wrap_m0: got %b expected %b", hgrant, 3'b001); end
        checks++; if (hmaster_data !== 2'd2) begin errors++; $display("FAIL burst_data_pipe: got %0d expected 2", hmaster_data); end
    endtask

    task automatic test_locked();
        do_reset();
        hreq      = 3'b001;
        hmastlock = 3'b001;
        set_htrans(NONSEQ, NONSEQ, NONSEQ);
        step();
        checks++; if (hgrant !== 3'b001) begin errors++; $display("FAIL lock_grant: got %b expected %b", hgrant, 3'b001); end
        checks++; if (hmaster_lock !== 1'b1) begin errors++; $display("FAIL lock_flag: got %b expected 1", hmaster_lock); end
        hreq = 3'b101;
        for (int t = 0; t < 2; t++) begin
            step();
            checks++; if (hgrant !== 3'b001) begin errors++; $display("FAIL lock_hold%0d: got %b expected %b", t, hgrant, 3'b001); end
        end
        hmastlock = 3'b000;
        step();
        checks++; if (hgrant !== 3'b100) begin errors++; $display("FAIL lock_release: got %b expected %b", hgrant, 3'b100); end
        checks++; if (hmaster_lock !== 1'b0) begin errors++; $display("FAIL lock_release_flag: got %b expected 0", hmaster_lock); end
    endtask

    // Continues from test_locked: master 2 owns, hmaster_data still 0.
    task automatic test_hready_stall();
        hready = 1'b0;
        hreq   = 3'b001;
        for (int t = 0; t < 3; t++) begin
            step();
            checks++; if (hgrant !== 3'b100) begin errors++; $display("FAIL stall_grant%0d: got %b expected %b", t, hgrant, 3'b100); end
            checks++; if (hmaster_addr !== 2'd2) begin errors++; $display("FAIL stall_addr%0d: got %0d expected 2", t, hmaster_addr); end
            checks++; if (hmaster_data !== 2'd0) begin errors++; $display("FAIL stall_data%0d: got %0d expected 0", t, hmaster_data); end
        end
        hready = 1'b1;
        step();
        checks++; if (hgrant !== 3'b001) begin errors++; $display("FAIL stall_resume_grant: got %b expected %b", hgrant, 3'b001); end
        checks++; if (hmaster_data !== 2'd2) begin errors++; $display("FAIL stall_resume_data: got %0d expected 2", hmaster_data); end
    endtask

    task automatic test_owner_drop();
        do_reset();
        hreq = 3'b100;
        set_htrans(NONSEQ, NONSEQ, NONSEQ);
        step();
        checks++; if (hgrant !== 3'b100) begin errors++; $display("FAIL drop_grant: got %b expected %b", hgrant, 3'b100); end
        set_htrans(NONSEQ, NONSEQ, SEQ);
        step();
        checks++; if (hgrant !== 3'b100) begin errors++; $display("FAIL drop_seq_hold: got %b expected %b", hgrant, 3'b100); end
        hreq = 3'b001;
        #1;
        checks++; if (hsel_slv !== 1'b0) begin errors++; $display("FAIL drop_hsel: got %b expected 0", hsel_slv); end
        step();
        checks++; if (hgrant !== 3'b001) begin errors++; $display("FAIL drop_regrant: got %b expected %b", hgrant, 3'b001); end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        hreq = 3'b010;
        set_htrans(NONSEQ, NONSEQ, NONSEQ);
        step();
        set_htrans(NONSEQ, SEQ, NONSEQ);
        step();
        #2;
        hreset_n = 1'b0;
        #1;
        checks++; if (hgrant !== 3'b000) begin errors++; $display("FAIL midrst_grant: got %b expected %b", hgrant, 3'b000); end
        checks++; if (hmaster_data !== 2'd0) begin errors++; $display("FAIL midrst_data: got %0d expected 0", hmaster_data); end
        checks++; if (hmaster_addr !== 2'd0) begin errors++; $display("FAIL midrst_addr: got %0d expected 0", hmaster_addr); end
        checks++; if (hsel_slv !== 1'b0) begin errors++; $display("FAIL midrst_hsel: got %b expected 0", hsel_slv); end
        hreset_n = 1'b1;
        hreq     = 3'b111;
        set_htrans(NONSEQ, NONSEQ, NONSEQ);
        step();
        checks++; if (hgrant !== 3'b001) begin errors++; $display("FAIL midrst_first_m0: got %b expected %b", hgrant, 3'b001); end
        checks++; if (hmaster_addr !== 2'd0) begin errors++; $display("FAIL midrst_first_addr: got %0d expected 0", hmaster_addr); end
    endtask

    initial begin
        test_reset();
        test_grant_latency();
        test_burst_hold();
        test_locked();
        test_hready_stall();
        test_owner_drop();
        test_reset_midburst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
